disp_7seg_ctrl: RTL and testbench

Display controller for the countdown-timer front panel, sitting between the timer/UI logic and the 8-digit 7-segment driver. It generates the digit-scan clock enable, applies leading-zero blanking and edit-mode blinking to the main timer value, and arbitrates a temporary message overlay that pre-empts the main value for a fixed hold time. All display-facing outputs are registered and feed the driver's CE, E, DP and IN inputs directly.

---
 rtl/disp_7seg_ctrl.sv | 102 ++++++++++
 tb/tb_disp_7seg_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/disp_7seg_ctrl.sv
// disp_7seg_ctrl: scan prescaler, leading-zero blanking, edit blink and timed message overlay for an 8-digit 7-segment driver.
module disp_7seg_ctrl #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLINK_DIV = 250,
  parameter int MSG_HOLD  = 16000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] MAIN_IN,
  input  logic [7:0]  MAIN_DP,
  input  logic [7:0]  EN_MASK,
  input  logic        LZB,
  input  logic [7:0]  EDIT_SEL,
  input  logic        MSG_REQ,
  input  logic [31:0] MSG_IN,
  input  logic [7:0]  MSG_DP,
  output logic        MSG_ACK,
  output logic        MSG_ACT,
  output logic        CE_SCAN,
  output logic [7:0]  E,
  output logic [7:0]  DP,
  output logic [31:0] Q
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  // one extra code point so the counter can hold MSG_HOLD itself
  localparam int HW = $clog2(MSG_HOLD + 1);
  typedef enum logic {MAIN, MSG} state_t;
  state_t      r_state, w_next;
  logic [PW-1:0] r_pre;
  logic [BW-1:0] r_bcnt;
  logic          r_ph;
  logic [HW-1:0] r_hold, w_hold;
  logic [31:0]   r_msg_q, w_msg_q;
  logic [7:0]    r_msg_dp, w_msg_dp;
  logic [7:0]    w_lz;
  logic          w_run;
  logic          w_bwrap;
  assign w_bwrap = r_bcnt == BW'(BLINK_DIV - 1);
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_pre  <= '0;
      r_bcnt <= '0;
      r_ph   <= 1'b0;
      CE_SCAN <= 1'b0;
    end else begin
      r_pre   <= r_pre == PW'(SCAN_DIV - 1) ? '0 : r_pre + 1'b1;
      CE_SCAN <= r_pre == PW'(SCAN_DIV - 1);
      if (CE_SCAN) begin
        r_bcnt <= w_bwrap ? '0 : r_bcnt + 1'b1;
        r_ph   <= w_bwrap ? ~r_ph : r_ph;
      end
    end
  end
  // blank from digit 7 downward until the first nonzero nibble; digit 0 always shows
  always_comb begin
    w_lz  = '0;
    w_run = LZB;
    for (int i = 7; i > 0; i--) begin
      w_run   = w_run && (MAIN_IN[4*i +: 4] == 4'h0);
      w_lz[i] = w_run;
    end
  end
  always_comb begin
    w_next   = r_state;
    w_hold   = r_hold;
    w_msg_q  = r_msg_q;
    w_msg_dp = r_msg_dp;
    if (MSG_REQ) begin
      w_next   = MSG;
      w_hold   = HW'(MSG_HOLD);
      w_msg_q  = MSG_IN;
      w_msg_dp = MSG_DP;
    end else if (r_state == MSG && CE_SCAN) begin
      w_hold = r_hold - 1'b1;
      w_next = r_hold == HW'(1) ? MAIN : MSG;
    end
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state  <= MAIN;
      r_hold   <= '0;
      r_msg_q  <= '0;
      r_msg_dp <= '0;
      MSG_ACK  <= 1'b0;
      MSG_ACT  <= 1'b0;
      Q        <= '0;
      DP       <= '0;
      E        <= '0;
    end else begin
      r_state  <= w_next;
      r_hold   <= w_hold;
      r_msg_q  <= w_msg_q;
      r_msg_dp <= w_msg_dp;
      MSG_ACK  <= MSG_REQ;
      MSG_ACT  <= w_next == MSG;
      Q        <= w_next == MSG ? w_msg_q : MAIN_IN;
      DP       <= w_next == MSG ? w_msg_dp : MAIN_DP;
      E        <= w_next == MSG ? EN_MASK : EN_MASK & ~w_lz & ~(r_ph ? EDIT_SEL : 8'h00);
    end
  end
endmodule

// File: tb/tb_disp_7seg_ctrl.sv
// tb_disp_7seg_ctrl: directed and randomized checks of disp_7seg_ctrl against an arithmetic timeline model.
module tb_disp_7seg_ctrl;
  localparam int S = 4;
  localparam int B = 3;
  localparam int H = 5;
  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [31:0] MAIN_IN = '0;
  logic [7:0]  MAIN_DP = '0;
  logic [7:0]  EN_MASK = '0;
  logic        LZB = 1'b0;
  logic [7:0]  EDIT_SEL = '0;
  logic        MSG_REQ = 1'b0;
  logic [31:0] MSG_IN = '0;
  logic [7:0]  MSG_DP = '0;
  logic        MSG_ACK, MSG_ACT, CE_SCAN;
  logic [7:0]  E, DP;
  logic [31:0] Q;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic        m_msg = 1'b0;
  logic [31:0] m_q = '0;
  logic [7:0]  m_dp = '0;
  int          m_end = 0;
  disp_7seg_ctrl #(.SCAN_DIV(S), .BLINK_DIV(B), .MSG_HOLD(H)) dut (
    .CLK(CLK), .CLR(CLR), .MAIN_IN(MAIN_IN), .MAIN_DP(MAIN_DP), .EN_MASK(EN_MASK),
    .LZB(LZB), .EDIT_SEL(EDIT_SEL), .MSG_REQ(MSG_REQ), .MSG_IN(MSG_IN), .MSG_DP(MSG_DP),
    .MSG_ACK(MSG_ACK), .MSG_ACT(MSG_ACT), .CE_SCAN(CE_SCAN), .E(E), .DP(DP), .Q(Q)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] lzmask(input logic [31:0] v, input logic en);
    logic [7:0] m;
    m = '0;
    for (int i = 7; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) break;
      m[i] = 1'b1;
    end
    return en ? m : 8'h00;
  endfunction
  // n counts clock edges since CLR released; pulse k is consumed on edge k*S+1
  task automatic step(input logic req);
    logic       ph;
    logic [7:0] e_exp;
    MSG_REQ = req;
    @(posedge CLK);
    n++;
    if (req) begin
      m_msg = 1'b1;
      m_q   = MSG_IN;
      m_dp  = MSG_DP;
      m_end = ((n - 1) / S + H) * S + 1;
    end else if (m_msg && n >= m_end) m_msg = 1'b0;
    ph = ((((n >= 2) ? (n - 2) / S : 0) / B) % 2) == 1;
    e_exp = m_msg ? EN_MASK : EN_MASK & ~lzmask(MAIN_IN, LZB) & ~(ph ? EDIT_SEL : 8'h00);
    #1;
    MSG_REQ = 1'b0;
    chk("ce_scan", 32'(CE_SCAN), 32'(n >= S && n % S == 0));
    chk("msg_ack", 32'(MSG_ACK), 32'(req));
    chk("msg_act", 32'(MSG_ACT), 32'(m_msg));
    chk("q", Q, m_msg ? m_q : MAIN_IN);
    chk("dp", 32'(DP), 32'(m_msg ? m_dp : MAIN_DP));
    chk("e", 32'(E), 32'(e_exp));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, Q, 32'h0);
    chk({tag, "_e"}, 32'(E), 32'h0);
    chk({tag, "_dp"}, 32'(DP), 32'h0);
    chk({tag, "_act"}, 32'(MSG_ACT), 32'h0);
    chk({tag, "_ack"}, 32'(MSG_ACK), 32'h0);
    chk({tag, "_ce"}, 32'(CE_SCAN), 32'h0);
  endtask
  initial begin
    MAIN_IN = 32'h00000305;
    MAIN_DP = 8'h5A;
    EN_MASK = 8'hFF;
    LZB = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset("rst");
    CLR = 1'b0;
    n = 0;
    m_msg = 1'b0;
    step(1'b0);
    chk("lz_305", 32'(E), 32'h07);
    repeat (12) step(1'b0);
    MAIN_IN = 32'h0;
    step(1'b0);
    chk("lz_zero", 32'(E), 32'h01);
    LZB = 1'b0;
    step(1'b0);
    chk("lz_off", 32'(E), 32'hFF);
    MAIN_IN = 32'h12345678;
    EDIT_SEL = 8'h0C;
    repeat (40) step(1'b0);
    MSG_IN = 32'h0000E55A;
    MSG_DP = 8'h81;
    step(1'b1);
    chk("msg_q", Q, 32'h0000E55A);
    chk("msg_e", 32'(E), 32'hFF);
    for (int i = 0; i < 100 && m_msg; i++) step(1'b0);
    chk("msg_done", 32'(MSG_ACT), 32'h0);
    chk("msg_revert", Q, MAIN_IN);
    MSG_IN = 32'hA1B2C3D4;
    step(1'b1);
    for (int i = 0; i < 100 && n < m_end - 1; i++) step(1'b0);
    MSG_IN = 32'h0BADF00D;
    step(1'b1);
    chk("collide_act", 32'(MSG_ACT), 32'h1);
    chk("collide_q", Q, 32'h0BADF00D);
    for (int i = 0; i < 100 && m_msg; i++) step(1'b0);
    chk("collide_done", 32'(MSG_ACT), 32'h0);
    MSG_IN = 32'h00C0FFEE;
    step(1'b1);
    repeat (3) step(1'b0);
    #1;
    CLR = 1'b1;
    #1;
    chk_reset("abort");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_reset("abort_hold");
    CLR = 1'b0;
    n = 0;
    m_msg = 1'b0;
    for (int i = 0; i < 400; i++) begin
      MAIN_IN  = $urandom >> (4 * $urandom_range(0, 8));
      MAIN_DP  = 8'($urandom);
      EN_MASK  = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
      LZB      = 1'($urandom);
      EDIT_SEL = 8'($urandom);
      MSG_IN   = $urandom;
      MSG_DP   = 8'($urandom);
      step($urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
